// File: rtl/fir_out_packer.sv
// Packs the 8-bit FIR result stream into 32-bit little-endian words and buffers
// them in a first-word-fall-through FIFO for a valid/ready consumer.
module fir_out_packer #(
  parameter int DEPTH = 8,
  parameter int DROPW = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic [7:0]               result,
  input  logic                     vldout,
  input  logic                     flush,
  output logic [31:0]              out_data,
  output logic [2:0]               out_bytes,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [DROPW-1:0]         drops
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]       cnt_q, cnt_d;
  logic [31:0]      pack_q, pack_d;
  logic [DROPW-1:0] drops_q, drops_d;
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [31:0]      mem_data_q [DEPTH];
  logic [2:0]       mem_bytes_q [DEPTH];

  logic        samp;
  logic [31:0] word;
  logic [2:0]  eff_cnt;
  logic        push, pop, full, wr_en, drop;

  // Handshake: the head word transfers on a clock edge where out_valid && out_ready;
  // out_valid depends only on registered pointers, never on out_ready.
  assign out_valid = (wr_ptr_q != rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop       = out_valid && out_ready;
  assign level     = wr_ptr_q - rd_ptr_q;
  assign drops     = drops_q;
  assign out_data  = out_valid ? mem_data_q[rd_ptr_q[AW-1:0]]  : 32'd0;
  assign out_bytes = out_valid ? mem_bytes_q[rd_ptr_q[AW-1:0]] : 3'd0;

  always_comb begin
    samp = enable && vldout;
    word = pack_q;
    if (samp) word[{cnt_q, 3'b000} +: 8] = result;
    // A sample arriving with flush is counted before deciding the word size.
    eff_cnt = {1'b0, cnt_q} + {2'b00, samp};
    push    = enable && ((samp && cnt_q == 2'd3) || (flush && eff_cnt != 3'd0));
    wr_en   = push && (!full || pop);
    drop    = push && full && !pop;

    cnt_d   = cnt_q;
    pack_d  = pack_q;
    drops_d = drops_q;
    if (!enable) begin
      cnt_d   = 2'd0;
      pack_d  = 32'd0;
      drops_d = '0;
    end else begin
      if (push) begin
        cnt_d  = 2'd0;
        pack_d = 32'd0;
      end else if (samp) begin
        cnt_d  = cnt_q + 2'd1;
        pack_d = word;
      end
      if (drop && drops_q != {DROPW{1'b1}}) drops_d = drops_q + DROPW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      pack_q   <= 32'd0;
      drops_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
      drops_q <= drops_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wr_ptr_q[AW-1:0]]  <= word;
      mem_bytes_q[wr_ptr_q[AW-1:0]] <= eff_cnt;
    end
  end

endmodule

// File: doc/fir_out_packer.md
Name: fir_out_packer

Overview:
- Downstream stage of the FIR datapath. Consumes the 8-bit result/vldout stream and packs four consecutive results into 32-bit little-endian words.
- Packed words are buffered in a small first-word-fall-through FIFO and presented on a valid/ready interface to a DMA or bus master.
- Keeps a saturating count of words dropped on FIFO overflow.
- enable comes from the same register file that enables the FIR goods/bads counters.

Parameters:
DEPTH, 8, FIFO depth in words; power of 2, minimum 2.
DROPW, 16, width of the dropped-word counter.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
enable  input  1  block enable (register-file bit)
result  input  8  FIR output sample
vldout  input  1  result valid, single-cycle qualifier
flush  input  1  single-cycle pulse; emits any partial word
out_data  output  32  head word; byte0 = oldest sample in [7:0]
out_bytes  output  3  valid bytes in head word, 1..4
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts head word when out_valid && out_ready
level  output  clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH
drops  output  DROPW  words lost to overflow; saturates at all-ones

Behaviour:
- Reset is asynchronous, active-low, clock clk. All state is zero at reset:
  - lane counter cnt[1:0] = 0 and pack register = 0;
  - FIFO pointers = 0, so out_valid = 0, level = 0, out_data = 0, out_bytes = 0;
  - drops = 0.
- Packing (enable = 1):
  - On vldout, result is written to lane cnt of the pack register and cnt increments.
  - When cnt == 3 and vldout: a full word (bytes = 4) is pushed and cnt returns to 0.
- Flush (enable = 1, flush = 1):
  - If the effective count is nonzero, a partial word is pushed. Unwritten lanes are 0 and bytes = count. cnt returns to 0.
  - The effective count includes a sample arriving in the same cycle.
  - Same-cycle vldout + flush: the sample is packed first, then a single push is made.
    - If that sample completes the word: one push, bytes = 4, never two pushes.
    - Example: cnt = 1 plus vldout plus flush gives one push with bytes = 2.
  - Flush with count 0 is a no-op.
- Enable low:
  - vldout and flush are ignored.
  - cnt and the pack register clear, so a partial word is discarded.
  - drops clears.
  - The FIFO is NOT cleared and keeps draining via out_ready.
- FIFO:
  - First-word-fall-through: out_data and out_bytes reflect the head entry combinationally from storage.
  - Push-to-out_valid latency is 1 cycle. A completing byte in cycle N gives out_valid = 1 in cycle N+1 when the FIFO was empty.
  - Pop occurs when out_valid && out_ready. Pointers wrap modulo DEPTH. level = wr_ptr - rd_ptr, using an extra wrap bit.
  - Push into a full FIFO with a pop in the same cycle is accepted; level stays DEPTH.
  - Push into a full FIFO without a pop:
    - the word is dropped and FIFO contents are unchanged;
    - drops increments, saturating at 2^DROPW - 1;
    - cnt still returns to 0, so packing restarts on the next sample.
  - Push and pop in the same cycle with a non-full FIFO: level is unchanged.
  - Pop when empty is ignored, since out_valid = 0.
- Ordering: words leave in push order. Bytes within a word are in arrival order, lane 0 first.
- No combinational path from out_ready to out_valid. The vldout-to-out_valid path is registered.

Test Plan:
- Reset → out_valid = 0, level = 0, drops = 0.
- enable = 1, results 0x11, 0x22, 0x33, 0x44 on consecutive cycles, out_ready = 1 → one cycle after 0x44: out_valid = 1, out_data = 0x44332211, out_bytes = 4. Next cycle level = 0.
- Results 0xAA, 0xBB, then flush → out_data = 0x0000BBAA, out_bytes = 2.
- Results 0x01, 0x02, 0x03, then 0x04 with flush in the same cycle → exactly one word, 0x04030201, bytes = 4. Nothing further is pushed.
- DEPTH = 8, out_ready = 0, 40 results (10 words) → level = 8, drops = 2. Then out_ready = 1 → 8 words drained in order, the first being 0x03020100 for samples 0, 1, 2, 3.
- 2 results then enable = 0 for 1 cycle, then 4 results 0x10..0x13 → only 0x13121110 appears; drops = 0.
- Full FIFO with simultaneous pop and completing push → level stays 8 and drops is unchanged.
